alu_seq: RTL

Multi-word operation sequencer for the 32-bit combinational `ALU`. It accepts a command of 1..256 words, streams operand word pairs through the ALU least-significant word first, and chains the X flag between words. Z accumulates across the whole operation, so 64/96/128-bit ADDX/SUBX/ROXx-style operations run on the single shared ALU. It also owns the architectural X flag register, which persists between commands.

---
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Command, operand and result channels of the multi-word ALU sequencer.
// The master side issues commands and operands and consumes results.
interface alu_seq_if #(
  parameter int N  = 32,
  parameter int LW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          cmd_xclr;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_A;
  logic [N-1:0]  in_B;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_RES;
  logic          out_last;
  logic [4:0]    out_XNZVC;
  logic          x_flag;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_xclr, in_valid, in_A, in_B, out_ready,
    input  cmd_ready, in_ready, out_valid, out_RES, out_last, out_XNZVC, x_flag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_xclr, in_valid, in_A, in_B, out_ready,
    output cmd_ready, in_ready, out_valid, out_RES, out_last, out_XNZVC, x_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Streams 1..256 operand word pairs through a shared 32-bit ALU, LSW first,
// chaining X between words, accumulating Z, and owning the architectural X flag.
module alu_seq #(
  parameter int N        = 32,
  parameter int LW       = 8,
  parameter int BITPOS_X = 4,
  parameter int BITPOS_Z = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_seq_if.slave     bus,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [3:0]   alu_OP,
  output logic         alu_X,
  input  logic [N-1:0] alu_RES,
  input  logic [4:0]   alu_XNZVC
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          x_cur_q, x_cur_d;
  logic          z_acc_q, z_acc_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_res_q, out_res_d;
  logic [4:0]    out_xnzvc_q, out_xnzvc_d;
  logic          out_last_q, out_last_d;
  logic          x_flag_q, x_flag_d;
  logic          in_ready_s;
  logic          fire_s;
  logic          last_s;

  // Gated by reset so no word can be offered a slot while the block is held.
  assign in_ready_s = reset && (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign fire_s     = bus.in_valid && in_ready_s;
  assign last_s     = (rem_q == {LW{1'b0}});

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_RES   = out_res_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_XNZVC = out_xnzvc_q;
  assign bus.x_flag    = x_flag_q;

  // ALU operand steering; parked at zero with the stored X while idle.
  always_comb begin
    alu_A  = {N{1'b0}};
    alu_B  = {N{1'b0}};
    alu_OP = 4'h0;
    alu_X  = x_flag_q;
    if (state_q == ST_RUN) begin
      alu_A  = bus.in_A;
      alu_B  = bus.in_B;
      alu_OP = op_q;
      alu_X  = x_cur_q;
    end else begin
      alu_X  = x_flag_q;
    end
  end

  // Next-state, flag chaining and result register update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rem_d       = rem_q;
    x_cur_d     = x_cur_q;
    z_acc_d     = z_acc_q;
    out_res_d   = out_res_q;
    out_xnzvc_d = out_xnzvc_q;
    out_last_d  = out_last_q;
    x_flag_d    = x_flag_q;

    // A new fire below overrides this, so retire and refill share one cycle.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          rem_d   = bus.cmd_len;
          x_cur_d = bus.cmd_xclr ? 1'b0 : x_flag_q;
          z_acc_d = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fire_s) begin
          out_res_d   = alu_RES;
          out_valid_d = 1'b1;
          out_last_d  = last_s;
          x_cur_d     = alu_XNZVC[BITPOS_X];
          z_acc_d     = z_acc_q & alu_XNZVC[BITPOS_Z];
          if (last_s) begin
            out_xnzvc_d           = alu_XNZVC;
            out_xnzvc_d[BITPOS_Z] = z_acc_q & alu_XNZVC[BITPOS_Z];
            x_flag_d              = alu_XNZVC[BITPOS_X];
            state_d               = ST_IDLE;
          end else begin
            out_xnzvc_d = 5'b0;
            rem_d       = rem_q - LW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'h0;
      rem_q       <= {LW{1'b0}};
      x_cur_q     <= 1'b0;
      z_acc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= {N{1'b0}};
      out_xnzvc_q <= 5'b0;
      out_last_q  <= 1'b0;
      x_flag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      x_cur_q     <= x_cur_d;
      z_acc_q     <= z_acc_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_xnzvc_q <= out_xnzvc_d;
      out_last_q  <= out_last_d;
      x_flag_q    <= x_flag_d;
    end
  end

endmodule
